// File: rtl/water_led_pkg.sv
// rtl/water_led_pkg.sv - shared encodings and constants for the water-light step sequencer
package water_led_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam int CLK_HZ  = 12_000_000;
    localparam int HEART_W = 4;

    // Terminal divider count for a speed setting: 2^(3-speed)-1.
    function automatic logic [2:0] speed_term(input logic [1:0] speed);
        return 3'b111 >> speed;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running base tick prescaler, frozen while en_in is low
module tick_prescaler #(
    parameter int PRESCALE = 1_500_000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic en_in,
    output logic tick_out
);

    localparam int             CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0]  TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Gated by the live enable so a pause on the terminal cycle suppresses the tick.
    assign tick_out = en_in && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (en_in) begin
            cnt_d = tick_out ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/heart_cnt_gen.sv
// rtl/heart_cnt_gen.sv - programmable step sequencer producing the LED position index
module heart_cnt_gen
    import water_led_pkg::*;
#(
    parameter int PRESCALE = 1_500_000,
    parameter int LED_NUM  = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               run_in,
    input  logic [1:0]         mode_in,
    input  logic [1:0]         speed_in,
    output logic [HEART_W-1:0] heart_cnt,
    output logic               step_out,
    output logic               wrap_out
);

    localparam logic [HEART_W-1:0] LAST = HEART_W'(LED_NUM - 1);
    localparam logic [HEART_W-1:0] ONE  = HEART_W'(1);

    logic               base_tick;
    logic               step_en;
    mode_e              mode;
    logic [2:0]         div_q, div_d;
    logic [1:0]         speed_q, speed_d;
    logic [HEART_W-1:0] heart_q, heart_d;
    logic               dir_up_q, dir_up_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en_in    (run_in),
        .tick_out (base_tick)
    );

    assign mode = mode_e'(mode_in);

    always_comb begin
        speed_d  = speed_in;
        step_en  = base_tick && (div_q == speed_term(speed_q));
        div_d    = div_q;
        heart_d  = heart_q;
        dir_up_d = dir_up_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;

        // A speed change restarts the divider so the new period starts cleanly.
        if (speed_in != speed_q) begin
            div_d = '0;
        end else if (base_tick) begin
            div_d = step_en ? 3'd0 : div_q + 3'd1;
        end

        if (step_en && (mode != MODE_HOLD)) begin
            step_d = 1'b1;
            case (mode)
                MODE_UP: begin
                    wrap_d  = (heart_q == LAST);
                    heart_d = wrap_d ? '0 : heart_q + ONE;
                end
                MODE_DOWN: begin
                    wrap_d  = (heart_q == '0);
                    heart_d = wrap_d ? LAST : heart_q - ONE;
                end
                MODE_PINGPONG: begin
                    // Reverse at an endpoint so it is shown once per sweep.
                    if (dir_up_q) begin
                        wrap_d   = (heart_q == LAST);
                        dir_up_d = !wrap_d;
                        heart_d  = wrap_d ? LAST - ONE : heart_q + ONE;
                    end else begin
                        wrap_d   = (heart_q == '0);
                        dir_up_d = wrap_d;
                        heart_d  = wrap_d ? ONE : heart_q - ONE;
                    end
                end
                default: begin
                    step_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q    <= '0;
            speed_q  <= 2'b00;
            heart_q  <= '0;
            dir_up_q <= 1'b1;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            speed_q  <= speed_d;
            heart_q  <= heart_d;
            dir_up_q <= dir_up_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign heart_cnt = heart_q;
    assign step_out  = step_q;
    assign wrap_out  = wrap_q;

endmodule

// File: tb/tb_heart_cnt_gen.sv
// tb/tb_heart_cnt_gen.sv - self-checking bench for heart_cnt_gen
module tb_heart_cnt_gen;

    localparam int P = 4;
    localparam int N = 8;
    localparam int L = N - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] heart;
    logic       step;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    heart_cnt_gen #(.PRESCALE(P), .LED_NUM(N)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .run_in    (run),
        .mode_in   (mode),
        .speed_in  (speed),
        .heart_cnt (heart),
        .step_out  (step),
        .wrap_out  (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: elapsed running cycles, base ticks per step, position by modular rules.
    int   m_pres, m_div, m_pos, m_up;
    int   m_step, m_wrap;
    logic [1:0] m_spd;
    int   n_pres, n_div, n_pos, n_up, n_step, n_wrap;
    int   bt, se;

    always_comb begin
        bt     = (run && m_pres == P - 1) ? 1 : 0;
        se     = (bt == 1 && m_div == (1 << (3 - m_spd)) - 1) ? 1 : 0;
        n_pres = run ? (m_pres + 1) % P : m_pres;
        n_div  = (speed !== m_spd) ? 0 : (bt == 1 ? (se == 1 ? 0 : m_div + 1) : m_div);
        n_step = (se == 1 && mode != 2'b11) ? 1 : 0;
        n_wrap = 0;
        n_pos  = m_pos;
        n_up   = m_up;
        if (n_step == 1) begin
            case (mode)
                2'b00: begin
                    n_pos  = (m_pos + 1) % N;
                    n_wrap = (m_pos == L) ? 1 : 0;
                end
                2'b01: begin
                    n_pos  = (m_pos + N - 1) % N;
                    n_wrap = (m_pos == 0) ? 1 : 0;
                end
                default: begin
                    if ((m_up == 1 && m_pos == L) || (m_up == 0 && m_pos == 0)) begin
                        n_up   = 1 - m_up;
                        n_wrap = 1;
                    end
                    n_pos = (n_up == 1) ? m_pos + 1 : m_pos - 1;
                end
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pres <= 0; m_div <= 0; m_pos <= 0; m_up <= 1;
            m_step <= 0; m_wrap <= 0; m_spd <= 2'b00;
        end else begin
            m_pres <= n_pres; m_div <= n_div; m_pos <= n_pos; m_up <= n_up;
            m_step <= n_step; m_wrap <= n_wrap; m_spd <= speed;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model_heart", 32'(heart), 32'(m_pos));
            check("model_step", 32'(step), 32'(m_step));
            check("model_wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    task automatic wait_step(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (step !== 1'b1 && cyc < maxc);
    endtask

    task automatic step_check(input string name, input int ecyc, input int eheart, input int ewrap);
        int c;
        wait_step(ecyc + 8, c);
        check({name, "_cycles"}, 32'(c), 32'(ecyc));
        check({name, "_heart"}, 32'(heart), 32'(eheart));
        check({name, "_wrap"}, 32'(wrap), 32'(ewrap));
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [1:0] s);
        rst_n = 1'b0;
        mode  = m;
        speed = s;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    int up_exp [8]    = '{1, 2, 3, 4, 5, 6, 7, 0};
    int pp_exp [15]   = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int pp2_exp [6]   = '{4, 5, 6, 7, 6, 5};

    initial begin
        rst_n = 1'b0; run = 1'b0; mode = 2'b00; speed = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("reset_heart", 32'(heart), 0);
        check("reset_step", 32'(step), 0);
        check("reset_wrap", 32'(wrap), 0);

        // Up-wrap at the fastest speed
        rst_n = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_check($sformatf("up%0d", i), 4, up_exp[i], (i == 7) ? 1 : 0);
        end

        // Ping-pong full sweep and return
        mode = 2'b10;
        for (int i = 0; i < 15; i++) begin
            step_check($sformatf("pp%0d", i), 4, pp_exp[i], (i == 7 || i == 14) ? 1 : 0);
        end

        // Down-wrap at the slowest speed
        do_reset(2'b01, 2'b00);
        step_check("down0", 32, 7, 1);
        step_check("down1", 32, 6, 0);

        // Pause with the prescaler at 2
        speed = 2'b11;
        step_check("fast_down", 4, 5, 0);
        repeat (2) @(posedge clk);
        #1;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("pause_heart%0d", i), 32'(heart), 5);
            check($sformatf("pause_step%0d", i), 32'(step), 0);
        end
        run = 1'b1;
        step_check("resume", 2, 4, 0);

        // Speed change with the divider at 5
        speed = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        speed = 2'b11;
        step_check("speed_chg", 4, 3, 0);

        // Hold keeps the position and suppresses pulses
        mode = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_heart%0d", i), 32'(heart), 3);
            check($sformatf("hold_step%0d", i), 32'(step), 0);
        end

        // Ping-pong up to the top and back to 5, leaving direction down
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step_check($sformatf("pp2_%0d", i), 4, pp2_exp[i], (i == 4) ? 1 : 0);
        end

        // Asynchronous reset mid-sweep
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_heart", 32'(heart), 0);
        check("midrst_step", 32'(step), 0);
        check("midrst_wrap", 32'(wrap), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_check("post_rst", 4, 1, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/heart_cnt_gen.md
# heart_cnt_gen

- Step sequencer that sits directly upstream of the 8-LED water-light driver.
- Divides the 12 MHz clock into a programmable step tick and generates the 4-bit `heart_cnt` index the driver decodes into a one-hot-low LED pattern.
- Supports up, down, ping-pong and hold sequencing, four speed settings and run/pause.
- Emits step and end-of-sweep pulses for other consumers, e.g. a buzzer or a segment display.

## Interface
- `PRESCALE`, default 1_500_000: clk_in cycles per base tick (8 Hz at 12 MHz); legal range ≥ 2.
- `LED_NUM`, default 8: number of positions; legal range 2..16; `LAST = LED_NUM-1`.
- `clk_in` input, 1 bit: system clock, 12 MHz.
- `rst_n_in` input, 1 bit: asynchronous, active-low reset.
- `run_in` input, 1 bit: 1 = sequencing; 0 = pause, freezing every counter and `heart_cnt`.
- `mode_in` input, 2 bits: 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold.
- `speed_in` input, 2 bits: one step every 2^(3-speed_in) base ticks (00 slowest = 8 ticks, 11 fastest = 1 tick).
- `heart_cnt` output, 4 bits: current position, always in 0..LAST.
- `step_out` output, 1 bit: one-cycle pulse on the cycle `heart_cnt` is updated by a step.
- `wrap_out` output, 1 bit: one-cycle pulse on wrap or ping-pong reversal.

## Operation
- **Reset values:** `heart_cnt`=0, `step_out`=0, `wrap_out`=0, prescaler=0, divider=0, direction=up, registered speed=00.
- **Prescaler:**
  - Counts 0..PRESCALE-1 when `run_in`=1 and holds its value when `run_in`=0.
  - `base_tick` = (prescaler==PRESCALE-1) & `run_in`; the prescaler returns to 0 on the following edge.
- **Divider:**
  - Counts base ticks 0..2^(3-speed)-1.
  - `step_en` = `base_tick` & (divider == 2^(3-speed)-1).
- **Speed change:** `speed_in` is registered every cycle. When the input differs from the registered value, the divider clears to 0 on that edge. The prescaler is unaffected.
- **mode 00 (up-wrap):** on `step_en`, `heart_cnt`+1; at LAST the next value is 0 and `wrap_out` pulses.
- **mode 01 (down-wrap):** on `step_en`, `heart_cnt`-1; at 0 the next value is LAST and `wrap_out` pulses.
- **mode 10 (ping-pong):**
  - The direction register selects +1 or -1.
  - At LAST going up: direction becomes down, next value is LAST-1, `wrap_out` pulses.
  - At 0 going down: direction becomes up, next value is 1, `wrap_out` pulses.
  - Each endpoint appears once per sweep, never twice in a row.
- **mode 11 (hold):** counters keep running; `heart_cnt`, direction, `step_out` and `wrap_out` are held (outputs 0).
- **Mode change:** takes effect at the next `step_en`. Direction is retained; it is only modified in mode 10 or by reset.
- **`run_in`=0:** all counters, `heart_cnt` and direction freeze; `step_out`/`wrap_out` are 0. On resume, counting continues from the frozen values with no lost or extra step.
- **Arithmetic:** no modulo-16 wrap is ever produced; for LED_NUM < 16, values above LAST are unreachable.
- **Reset mid-sweep:** asynchronous return to reset values. The first step after release occurs PRESCALE·2^(3-speed) cycles later.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `heart_cnt`, `step_out` and `wrap_out` update on the same edge: the edge where the prescaler wraps and the divider reaches its terminal count.
- Step period with `run_in` held high is exactly PRESCALE·2^(3-speed_in) clk_in cycles.
- `step_out` and `wrap_out` are exactly 1 cycle wide; `wrap_out` is only ever asserted together with `step_out`.
- A `run_in` fall on the terminal cycle suppresses that step: `base_tick` is gated by the current `run_in`.
- `mode_in`/`speed_in` are synchronous to `clk_in`; no synchroniser is included.

## Structure
- **Package `water_led_pkg`:**
  - Mode encodings `MODE_UP`=2'b00, `MODE_DOWN`=2'b01, `MODE_PINGPONG`=2'b10, `MODE_HOLD`=2'b11.
  - Default constant `CLK_HZ`=12_000_000.
  - Width constant `HEART_W`=4, shared with the LED driver.
- **Sub-module `tick_prescaler`:** parameter PRESCALE, inputs `clk_in`, `rst_n_in`, `en_in`, output `tick_out`. Counter width is $clog2(PRESCALE).
- The divider, direction register and next-`heart_cnt` logic stay in the top module.

## Test plan
All scenarios use PRESCALE=4, LED_NUM=8.
- **Up-wrap, fastest:** mode 00, speed 11, `run_in`=1 after reset → `heart_cnt` 1,2,…,7,0 at 4-cycle spacing; `wrap_out` only on the 7→0 edge; first `step_out` 4 cycles after reset release.
- **Ping-pong sequence:** mode 10, speed 11 → sequence 1..7,6..0,1; `wrap_out` on steps producing 6 and 1; no repeated endpoint.
- **Down-wrap, slowest:** mode 01, speed 00 → 0→7 after 32 cycles with `wrap_out`, then 6 after a further 32 cycles.
- **Pause and resume:** `run_in` low for 10 cycles mid-period (prescaler=2) → `heart_cnt` frozen and no pulses; next step is 2 cycles after `run_in` returns high.
- **Speed change mid-count:** change speed 00→11 when divider=5 → divider cleared; next step at the following prescaler wrap. Separately, mode 11 for 20 cycles → `heart_cnt` constant and `step_out`=0.
- **Reset mid-sweep:** assert `rst_n_in` low with `heart_cnt`=5 and direction=down → all outputs return to reset values immediately; after release, mode 10 steps go 0→1 (direction up).
